// File: rtl/rc_pwm_receiver_if.sv
// Interface bundling the RC receiver pin-side inputs and frame outputs.
//   ctrl_inputs  raw asynchronous PWM inputs, one per channel
//   data         channel widths in us, ch0 in bits [WIDTH-1:0]
//   ch_valid     per-channel "receiving in-range pulses"
//   failsafe     any channel lost
//   pulse_err    per-channel 1-cycle flag: out-of-range pulse discarded
//   data_rdy     1-cycle strobe: new frame on data
// master = pin driver / frame consumer, slave = the receiver itself.
interface rc_pwm_receiver_if #(
    parameter int NUM_CH = 4,
    parameter int WIDTH  = 12
);
    logic [NUM_CH-1:0]       ctrl_inputs;
    logic [NUM_CH*WIDTH-1:0] data;
    logic [NUM_CH-1:0]       ch_valid;
    logic                    failsafe;
    logic [NUM_CH-1:0]       pulse_err;
    logic                    data_rdy;

    modport master (
        output ctrl_inputs,
        input  data, ch_valid, failsafe, pulse_err, data_rdy
    );

    modport slave (
        input  ctrl_inputs,
        output data, ch_valid, failsafe, pulse_err, data_rdy
    );
endinterface

// File: rtl/rc_pwm_receiver.sv
// RC PWM receiver front end: measures the high time of NUM_CH PWM inputs in
// microsecond ticks, range-checks each pulse, times out each channel
// independently, substitutes FAILSAFE_US on lost channels and publishes a
// coherent frame with a one-cycle data_rdy strobe.
// Ports:
//   clk_system  system clock, all logic on the rising edge
//   reset_n     synchronous active-low reset
//   rx_bus      rc_pwm_receiver_if.slave (ctrl_inputs in; data, ch_valid,
//               failsafe, pulse_err, data_rdy out)
module rc_pwm_receiver #(
    parameter int NUM_CH      = 4,
    parameter int WIDTH       = 12,
    parameter int TICK_DIV    = 50,
    parameter int MIN_US      = 900,
    parameter int MAX_US      = 2100,
    parameter int TIMEOUT_US  = 25000,
    parameter int FAILSAFE_US = 1000
) (
    input  logic               clk_system,
    input  logic               reset_n,
    rc_pwm_receiver_if.slave   rx_bus
);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int TW = $clog2(TIMEOUT_US + 1);

    localparam logic [PW-1:0]    PRE_LAST = PW'(TICK_DIV - 1);
    localparam logic [WIDTH-1:0] MIN_W    = WIDTH'(MIN_US);
    localparam logic [WIDTH-1:0] MAX_W    = WIDTH'(MAX_US);
    localparam logic [WIDTH-1:0] FS_W     = WIDTH'(FAILSAFE_US);
    localparam logic [TW-1:0]    TO_MAX   = TW'(TIMEOUT_US);
    localparam logic [TW-1:0]    TO_LAST  = TW'(TIMEOUT_US - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HIGH,
        ST_STUCK
    } state_t;

    logic [PW-1:0]           r_pre;
    logic [NUM_CH-1:0]       r_sync1;
    logic [NUM_CH-1:0]       r_sync2;
    logic [NUM_CH-1:0]       r_prev;
    logic [NUM_CH-1:0]       r_rise;
    logic [NUM_CH-1:0]       r_fall;
    state_t                  r_state [NUM_CH];
    logic [WIDTH-1:0]        r_cnt   [NUM_CH];
    logic [TW-1:0]           r_to    [NUM_CH];
    logic [NUM_CH*WIDTH-1:0] r_data;
    logic [NUM_CH-1:0]       r_valid;
    logic [NUM_CH-1:0]       r_fresh;
    logic [NUM_CH-1:0]       r_err;
    logic                    r_fs_d;
    logic                    r_fs_rdy;

    logic w_tick;
    logic w_failsafe;
    logic w_frame;
    logic w_rdy;

    assign w_tick     = (r_pre == PRE_LAST);
    assign w_failsafe = ~(&r_valid);
    // A frame is complete once every live channel has a fresh sample.
    assign w_frame    = (&(r_fresh | ~r_valid)) & (|r_fresh);
    assign w_rdy      = w_frame | r_fs_rdy;

    always_ff @(posedge clk_system) begin
        if (!reset_n) begin
            r_pre    <= '0;
            r_sync1  <= '0;
            r_sync2  <= '0;
            r_prev   <= '0;
            r_rise   <= '0;
            r_fall   <= '0;
            r_data   <= {NUM_CH{FS_W}};
            r_valid  <= '0;
            r_fresh  <= '0;
            r_err    <= '0;
            // Failsafe is already asserted out of reset; that is not a rise.
            r_fs_d   <= 1'b1;
            r_fs_rdy <= 1'b0;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                r_state[i] <= ST_IDLE;
                r_cnt[i]   <= '0;
                r_to[i]    <= '0;
            end
        end else begin
            r_pre    <= w_tick ? '0 : r_pre + 1'b1;
            r_sync1  <= rx_bus.ctrl_inputs;
            r_sync2  <= r_sync1;
            r_prev   <= r_sync2;
            // Registered edge strobes give a fixed 3-cycle input-to-FSM latency.
            r_rise   <= r_sync2 & ~r_prev;
            r_fall   <= ~r_sync2 & r_prev;
            r_fs_d   <= w_failsafe;
            r_fs_rdy <= w_failsafe & ~r_fs_d;
            r_err    <= '0;

            // Frame clear first; a same-cycle latch below sets its bit again.
            if (w_rdy) begin
                r_fresh <= '0;
            end

            for (int unsigned i = 0; i < NUM_CH; i++) begin
                if (w_tick && (r_to[i] != TO_MAX)) begin
                    r_to[i] <= r_to[i] + 1'b1;
                    if (r_to[i] == TO_LAST) begin
                        r_valid[i]                <= 1'b0;
                        r_data[i*WIDTH +: WIDTH]  <= FS_W;
                    end
                end

                case (r_state[i])
                    ST_IDLE: begin
                        if (r_rise[i]) begin
                            r_cnt[i]   <= '0;
                            r_state[i] <= ST_HIGH;
                        end
                    end
                    ST_HIGH: begin
                        if (r_fall[i]) begin
                            r_state[i] <= ST_IDLE;
                            // cnt never exceeds MAX_US here: MAX_US+1 leaves for STUCK.
                            if (r_cnt[i] >= MIN_W) begin
                                r_data[i*WIDTH +: WIDTH] <= r_cnt[i];
                                r_fresh[i]               <= 1'b1;
                                r_valid[i]               <= 1'b1;
                                r_to[i]                  <= '0;
                            end else begin
                                r_err[i] <= 1'b1;
                            end
                        end else if (w_tick) begin
                            r_cnt[i] <= r_cnt[i] + 1'b1;
                            if (r_cnt[i] == MAX_W) begin
                                r_state[i] <= ST_STUCK;
                            end
                        end
                    end
                    ST_STUCK: begin
                        if (r_fall[i]) begin
                            r_err[i]   <= 1'b1;
                            r_state[i] <= ST_IDLE;
                        end
                    end
                    default: begin
                        r_state[i] <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign rx_bus.data      = r_data;
    assign rx_bus.ch_valid  = r_valid;
    assign rx_bus.failsafe  = w_failsafe;
    assign rx_bus.pulse_err = r_err;
    assign rx_bus.data_rdy  = w_rdy;

endmodule
